// File: rtl/kbd_pkg.sv
// Shared types and constants for the keypad entry controller.
package kbd_pkg;
  typedef enum logic [1:0] {
    SHOW_TIME  = 2'd0,
    KEY_STORED = 2'd1,
    KEY_WAIT   = 2'd2
  } kbd_state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_BS   = 8'h08;

  localparam int TIMEOUT_SEC_DEF = 10;
  localparam int NUM_DIGITS_DEF  = 4;
endpackage

// File: rtl/kbd_ascii_decode.sv
// ASCII key code to BCD; mirror of the display's BCD-to-ASCII mapping.
module kbd_ascii_decode
  import kbd_pkg::*;
(
  input  logic [7:0] key_code,
  output logic       is_digit,
  output logic       is_bs,
  output logic [3:0] bcd
);
  always_comb begin
    is_digit = (key_code >= ASCII_ZERO) && (key_code <= ASCII_NINE);
    is_bs    = (key_code == ASCII_BS);
    // '0'..'9' carry the digit value in their low nibble
    bcd      = is_digit ? key_code[3:0] : 4'h0;
  end
endmodule

// File: rtl/kbd_key_entry.sv
// Keypad entry FSM: buffers HH:MM digits, commits to alarm/time on button.
// Optional backspace support: define KBD_BACKSPACE_EN.
module kbd_key_entry
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_SEC = TIMEOUT_SEC_DEF,
  parameter int NUM_DIGITS  = NUM_DIGITS_DEF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [7:0]              key_code,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic                    one_second,
  input  logic                    alarm_button,
  input  logic                    time_button,
  output logic [3:0]              key,
  output logic [4*NUM_DIGITS-1:0] key_buffer,
  output logic                    show_new_time,
  output logic                    show_a,
  output logic                    load_new_a,
  output logic                    load_new_c,
  output logic                    key_error
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int TW = $clog2(TIMEOUT_SEC + 1);
  localparam int CW = $clog2(NUM_DIGITS + 1);

  kbd_state_e    state_q, state_d;
  logic [BW-1:0] buf_d;
  logic [3:0]    key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          load_a_d, load_c_d, err_d;
  logic          is_digit, is_bs, bs_ok, xfer;
  logic [3:0]    bcd;

  kbd_ascii_decode u_dec (
    .key_code (key_code),
    .is_digit (is_digit),
    .is_bs    (is_bs),
    .bcd      (bcd)
  );

`ifdef KBD_BACKSPACE_EN
  assign bs_ok = is_bs;
`else
  logic unused_bs;
  assign unused_bs = is_bs;
  assign bs_ok     = 1'b0;
`endif

  assign key_ready     = ((state_q == SHOW_TIME) || (state_q == KEY_WAIT))
                         && !alarm_button && !time_button;
  assign xfer          = key_valid && key_ready;
  assign show_new_time = (state_q != SHOW_TIME);
  assign show_a        = (state_q == SHOW_TIME) && alarm_button;

  always_comb begin
    state_d  = state_q;
    buf_d    = key_buffer;
    key_d    = key;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    load_a_d = 1'b0;
    load_c_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      SHOW_TIME: begin
        if (xfer) begin
          if (is_digit) begin
            buf_d   = BW'(bcd);
            key_d   = bcd;
            cnt_d   = CW'(1);
            tmo_d   = '0;
            state_d = KEY_STORED;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      KEY_STORED: state_d = KEY_WAIT;
      KEY_WAIT: begin
        // buttons block key_ready, so they never collide with a transfer
        if (alarm_button) begin
          load_a_d = 1'b1;
          tmo_d    = '0;
          state_d  = SHOW_TIME;
        end else if (time_button) begin
          load_c_d = 1'b1;
          tmo_d    = '0;
          state_d  = SHOW_TIME;
        end else if (xfer && is_digit) begin
          buf_d   = {key_buffer[BW-5:0], bcd};
          key_d   = bcd;
          cnt_d   = (cnt_q == CW'(NUM_DIGITS)) ? cnt_q : cnt_q + CW'(1);
          tmo_d   = '0;
          state_d = KEY_STORED;
        end else if (xfer && bs_ok) begin
          buf_d   = {4'h0, key_buffer[BW-1:4]};
          key_d   = key_buffer[7:4];
          cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
          tmo_d   = '0;
          if (cnt_q <= CW'(1)) state_d = SHOW_TIME;
        end else if (xfer) begin
          err_d = 1'b1;
        end else if (one_second) begin
          if (tmo_q == TW'(TIMEOUT_SEC - 1)) begin
            buf_d   = '0;
            cnt_d   = '0;
            tmo_d   = '0;
            state_d = SHOW_TIME;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      default: state_d = SHOW_TIME;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= SHOW_TIME;
      key_buffer <= '0;
      key        <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      load_new_a <= 1'b0;
      load_new_c <= 1'b0;
      key_error  <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_buffer <= buf_d;
      key        <= key_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      load_new_a <= load_a_d;
      load_new_c <= load_c_d;
      key_error  <= err_d;
    end
  end
endmodule

// File: tb/tb_kbd_key_entry.sv
// Randomized + directed bench for kbd_key_entry against a digit-queue model.
module tb_kbd_key_entry;
  localparam int TMO = 3;
`ifdef KBD_BACKSPACE_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n, key_valid, one_second, alarm_button, time_button;
  logic [7:0]  key_code;
  logic        key_ready, show_new_time, show_a, load_new_a, load_new_c, key_error;
  logic [3:0]  key;
  logic [15:0] key_buffer;

  kbd_key_entry #(.TIMEOUT_SEC(TMO), .NUM_DIGITS(4)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .one_second    (one_second),
    .alarm_button  (alarm_button),
    .time_button   (time_button),
    .key           (key),
    .key_buffer    (key_buffer),
    .show_new_time (show_new_time),
    .show_a        (show_a),
    .load_new_a    (load_new_a),
    .load_new_c    (load_new_c),
    .key_error     (key_error)
  );

  always #5 clock = ~clock;

  int nchk = 0;
  int nerr = 0;

  // model: ph 0 = showing time, 1 = digit just taken, 2 = waiting for more
  int ph = 0;
  int dq[$];
  int mkey = 0;
  int secs = 0;
  bit m_la, m_lc, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mbuf();
    logic [15:0] b = '0;
    for (int i = 0; i < dq.size(); i++)
      b = b | (16'(dq[dq.size()-1-i]) << (4*i));
    return b;
  endfunction

  task automatic cyc(input bit rst, input bit kv, input logic [7:0] kc,
                     input bit ab, input bit tb, input bit os);
    bit rdy, xfer, isd, isbs;
    int d;
    reset_n = !rst; key_valid = kv; key_code = kc;
    alarm_button = ab; time_button = tb; one_second = os;
    #1;
    rdy = (ph != 1) && !ab && !tb;
    if (!rst) begin
      chk("key_ready", key_ready, rdy);
      chk("show_a", show_a, (ph == 0) && ab);
      chk("show_new_time_pre", show_new_time, ph != 0);
    end
    m_la = 0; m_lc = 0; m_err = 0;
    xfer = kv && rdy;
    isd  = (kc >= 8'h30) && (kc <= 8'h39);
    d    = int'(kc) - 32'h30;
    isbs = BS_EN && (kc == 8'h08);
    if (rst) begin
      ph = 0; dq.delete(); mkey = 0; secs = 0;
    end else if (ph == 0) begin
      if (xfer) begin
        if (isd) begin dq.delete(); dq.push_back(d); mkey = d; ph = 1; end
        else m_err = 1;
      end
    end else if (ph == 1) begin
      ph = 2;
    end else begin
      if (ab) begin m_la = 1; ph = 0; secs = 0; end
      else if (tb) begin m_lc = 1; ph = 0; secs = 0; end
      else if (xfer && isd) begin
        dq.push_back(d);
        if (dq.size() > 4) void'(dq.pop_front());
        mkey = d; secs = 0; ph = 1;
      end else if (xfer && isbs) begin
        void'(dq.pop_back());
        mkey = (dq.size() > 0) ? dq[dq.size()-1] : 0;
        secs = 0;
        if (dq.size() == 0) ph = 0;
      end else if (xfer) begin
        m_err = 1;
      end else if (os) begin
        secs++;
        if (secs == TMO) begin dq.delete(); secs = 0; ph = 0; end
      end
    end
    @(posedge clock);
    #1;
    chk("key", key, mkey);
    chk("key_buffer", key_buffer, mbuf());
    chk("load_new_a", load_new_a, m_la);
    chk("load_new_c", load_new_c, m_lc);
    chk("key_error", key_error, m_err);
    chk("show_new_time", show_new_time, ph != 0);
  endtask

  task automatic dig(input logic [7:0] kc);
    cyc(0, 1, kc, 0, 0, 0);
    cyc(0, 0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    int r;
    logic [7:0] kc;
    cyc(1, 0, 8'h00, 0, 0, 0);
    cyc(1, 0, 8'h00, 0, 0, 0);
    chk("rst_buf", key_buffer, 16'h0000);
    chk("rst_key", key, 4'h0);

    // four digits committed to the current time
    dig(8'h31); dig(8'h32); dig(8'h33); dig(8'h34);
    cyc(0, 0, 8'h00, 0, 1, 0);
    chk("t1_load_c", load_new_c, 1'b1);
    chk("t1_buf", key_buffer, 16'h1234);
    cyc(0, 0, 8'h00, 0, 1, 0);
    chk("t1_no_retrig", load_new_c, 1'b0);

    // single digit to alarm, then alarm held in SHOW_TIME
    dig(8'h37);
    cyc(0, 0, 8'h00, 1, 0, 0);
    chk("t2_load_a", load_new_a, 1'b1);
    chk("t2_buf", key_buffer, 16'h0007);
    cyc(0, 0, 8'h00, 1, 0, 0);
    cyc(0, 0, 8'h00, 1, 0, 0);
    chk("t2_show_a", show_a, 1'b1);
    chk("t2_no_strobe", load_new_a, 1'b0);

    // timeout abandons entry
    dig(8'h35);
    for (int i = 0; i < TMO; i++) cyc(0, 0, 8'h00, 0, 0, 1);
    chk("t3_show_time", show_new_time, 1'b0);
    chk("t3_buf", key_buffer, 16'h0000);

    // bad code, then key racing a button
    dig(8'h31);
    cyc(0, 1, 8'h41, 0, 0, 0);
    chk("t4_err", key_error, 1'b1);
    chk("t4_buf", key_buffer, 16'h0001);
    cyc(0, 0, 8'h00, 0, 0, 0);
    chk("t4_err_off", key_error, 1'b0);
    cyc(0, 1, 8'h39, 0, 1, 0);
    chk("t4_key_not_taken", key, 4'h1);
    chk("t4_load_c", load_new_c, 1'b1);

    // overflow keeps the last four, then reset mid-entry
    dig(8'h31); dig(8'h32); dig(8'h33); dig(8'h34); dig(8'h35);
    chk("t5_buf", key_buffer, 16'h2345);
    cyc(1, 0, 8'h00, 0, 0, 0);
    chk("t5_rst_buf", key_buffer, 16'h0000);
    chk("t5_rst_snt", show_new_time, 1'b0);

    dig(8'h31);
`ifdef KBD_BACKSPACE_EN
    dig(8'h32);
    cyc(0, 1, 8'h08, 0, 0, 0);
    chk("t6_bs_buf", key_buffer, 16'h0001);
    chk("t6_bs_key", key, 4'h1);
    cyc(0, 1, 8'h08, 0, 0, 0);
    chk("t6_bs_exit", show_new_time, 1'b0);
`else
    cyc(0, 1, 8'h08, 0, 0, 0);
    chk("t6_bs_err", key_error, 1'b1);
`endif

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       kc = 8'h30 + 8'($urandom_range(0, 9));
      else if (r == 7) kc = 8'h41;
      else if (r == 8) kc = 8'h08;
      else             kc = 8'($urandom);
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, kc,
          $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
          $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/kbd_key_entry.md
# kbd_key_entry

Keypad entry controller for the alarm clock. Accepts ASCII key codes from the keypad interface over a valid/ready handshake and decodes them to BCD, the inverse of the display path's BCD-to-ASCII mapping. It buffers up to four digits (HH:MM) and runs the entry state machine. It drives `key`, `show_new_time` and `show_a` into the LCD driver, and one-cycle load strobes into the alarm and time registers.

## Interface
- `TIMEOUT_SEC`, default 10: idle seconds in KEY_WAIT before entry is abandoned.
- `NUM_DIGITS`, default 4: digit buffer depth.
- `clock`  in  1: system clock; all state changes on the rising edge.
- `reset_n`  in  1: reset, **synchronous, active-low**.
- `key_code`  in  8: ASCII code from the keypad.
- `key_valid`  in  1: `key_code` is valid.
- `key_ready`  out  1: block can accept a code this cycle.
- `one_second`  in  1: single-cycle tick, once per second.
- `alarm_button`  in  1: level; show alarm, or commit entry to the alarm.
- `time_button`  in  1: level; commit entry to the current time.
- `key`  out  4: last accepted digit (BCD).
- `key_buffer`  out  4*NUM_DIGITS: entered digits; most recent in the low nibble.
- `show_new_time`  out  1: display shows `key`.
- `show_a`  out  1: display shows the alarm time.
- `load_new_a`  out  1: one-cycle strobe; load `key_buffer` into the alarm register.
- `load_new_c`  out  1: one-cycle strobe; load `key_buffer` into the current time.
- `key_error`  out  1: one-cycle pulse; accepted code was not a digit.

## Operation
- States: SHOW_TIME, KEY_STORED, KEY_WAIT.
- Transfer occurs when `key_valid && key_ready`.
- `key_ready` is combinational: (state is SHOW_TIME or KEY_WAIT) and `!alarm_button` and `!time_button`.
- Decode: 8'h30..8'h39 map to 0..9. Any other code is accepted and dropped: it pulses `key_error`, and state, buffer and digit count are unchanged.
- SHOW_TIME:
  - `show_a` = `alarm_button`.
  - On a valid digit: clear the buffer, write the digit into the low nibble, set count=1, go to KEY_STORED.
  - Buttons with no entry in progress produce no load strobes.
- KEY_STORED (exactly one cycle): `show_new_time`=1, then go to KEY_WAIT.
- KEY_WAIT:
  - `show_new_time`=1.
  - On a valid digit: shift `key_buffer` left one nibble, insert the digit, count saturates at NUM_DIGITS, clear the timeout counter, go to KEY_STORED.
  - `alarm_button`: pulse `load_new_a`, go to SHOW_TIME.
  - Else `time_button`: pulse `load_new_c`, go to SHOW_TIME.
  - Both buttons high: alarm wins.
  - Each `one_second` increments the timeout counter. Reaching TIMEOUT_SEC clears the buffer and count, then goes to SHOW_TIME with no load.
- `key_buffer` keeps its value through the load cycle and clears on the next entry.
- Timeout counter width is $clog2(TIMEOUT_SEC+1). It runs only in KEY_WAIT.

## Timing
- Reset values: state SHOW_TIME, `key`=0, `key_buffer`=0, count=0, timeout=0, and all strobes, `show_*` and `key_error` = 0.
- Accept at edge N: `key` and `key_buffer` are updated and KEY_STORED is visible in cycle N+1. KEY_WAIT is entered in cycle N+2. Maximum rate is one key per 2 cycles.
- `key_error` is asserted in cycle N+1 only.
- A load strobe is asserted in the cycle after the button is sampled in KEY_WAIT, for 1 cycle. A button held longer does not retrigger, because the state is then SHOW_TIME.
- Timeout: the TIMEOUT_SEC-th tick in KEY_WAIT produces SHOW_TIME on the next cycle.
- A key and a button in the same cycle: `key_ready` is 0, the key is not accepted, and the button takes effect.
- Reset asserted mid-entry: return to reset values on that edge. No strobes are emitted.

## Configuration
- `KBD_BACKSPACE_EN` defined:
  - In KEY_WAIT, ASCII 8'h08 is accepted as backspace.
  - `key_buffer` shifts right one nibble, count decrements (floor 0), and the timeout counter clears.
  - `key` becomes the new low nibble.
  - Count reaching 0 goes to SHOW_TIME.
  - No `key_error` is raised.
- Macro not defined: 8'h08 is an invalid code and raises `key_error`.

## Structure
- Package `kbd_pkg`:
  - State enum.
  - ASCII constants ASCII_ZERO=8'h30, ASCII_NINE=8'h39, ASCII_BS=8'h08.
  - Default TIMEOUT_SEC.
- Sub-module `kbd_ascii_decode`, combinational: `key_code` to {is_digit, is_bs, bcd[3:0]}. It is the mirror of the display decoder.

## Test plan
- Reset, then send 8'h31,8'h32,8'h33,8'h34, then time_button -> key_buffer=16'h1234, `load_new_c` high 1 cycle, state SHOW_TIME.
- Send 8'h37, then alarm_button in KEY_WAIT -> key_buffer=16'h0007, `load_new_a` pulse. Alarm_button held in SHOW_TIME -> `show_a`=1 with no strobe.
- Send 8'h35, then TIMEOUT_SEC `one_second` ticks -> SHOW_TIME, key_buffer=0, no load strobes.
- Send 8'h41 -> `key_error` 1 cycle, state and buffer unchanged. Send 8'h39 with time_button high in the same cycle -> `key_ready`=0, the key is not taken.
- Send five digits 1..5 -> key_buffer=16'h2345, count=4. Assert reset_n=0 mid-entry -> all outputs return to reset values on the next edge.
- With KBD_BACKSPACE_EN: send 8'h31,8'h32,8'h08 -> key_buffer=16'h0001, `key`=1. A second 8'h08 -> SHOW_TIME. Without the macro, 8'h08 -> `key_error`.
